// File: rtl/loba_split_pipe_pkg.sv
// loba_pkg: constants, split record type and segment-extraction helpers for the
// LOBA2 (16-bit operand, 4-bit segment) approximate multiplier front end.
//
// Optional feature macro: LOBA_SPLIT_ZERO_FLAG_EN adds a 'zero' field to
// loba_split_t, which is set when the split operand was 0.
//
// Contents:
//   LOBA_W, LOBA_SEG, LOBA_KW, LOBA_KMIN  widths and the minimum k value
//   loba_split_t                          one operand's split fields
//   loba_split_reset()                    value of a split record after reset
//   loba_split(x, p, nz)                  split rule for one operand
package loba_pkg;

  localparam int LOBA_W    = 16;
  localparam int LOBA_SEG  = 4;
  localparam int LOBA_KW   = 4;
  localparam int LOBA_KMIN = 3;

  // Smallest k; downstream k-sums subtract 6, so no k may go below this.
  localparam logic [LOBA_KW-1:0] LOBA_K_MIN_V   = 4'd3;
  // Largest leading-one index whose split is still exact.
  localparam logic [LOBA_KW-1:0] LOBA_P_EXACT   = 4'd6;
  // Distance from the leading one to the LSB of the low segment.
  localparam logic [LOBA_KW-1:0] LOBA_LO_OFS    = 4'd7;
  // Distance from kh to kl when the low segment sits right below the high one.
  localparam logic [LOBA_KW-1:0] LOBA_SEG_STEP  = 4'd4;

  typedef struct packed {
    logic [LOBA_SEG-1:0] xh;
    logic [LOBA_KW-1:0]  kh;
    logic [LOBA_SEG-1:0] xl;
    logic [LOBA_KW-1:0]  kl;
`ifdef LOBA_SPLIT_ZERO_FLAG_EN
    logic                zero;
`endif
  } loba_split_t;

  // Reset / zero-operand record: empty segments, both k at the minimum.
  function automatic loba_split_t loba_split_reset();
    loba_split_t s;
    s.xh = {LOBA_SEG{1'b0}};
    s.kh = LOBA_K_MIN_V;
    s.xl = {LOBA_SEG{1'b0}};
    s.kl = LOBA_K_MIN_V;
`ifdef LOBA_SPLIT_ZERO_FLAG_EN
    s.zero = 1'b1;
`endif
    return s;
  endfunction

  // Split one operand given its leading-one index p and nonzero flag nz.
  // The high window is X[p:p-3]; the remainder R is X with that window cleared.
  // Shift amounts wrap for small p but are only used on branches where p is
  // large enough for them to be meaningful.
  function automatic loba_split_t loba_split(input logic [LOBA_W-1:0]  x,
                                             input logic [LOBA_KW-1:0] p,
                                             input logic               nz);
    loba_split_t         s;
    logic [LOBA_KW-1:0]  sh_hi;
    logic [LOBA_KW-1:0]  sh_lo;
    logic [LOBA_W-1:0]   x_hi;
    logic [LOBA_W-1:0]   rem;
    logic [LOBA_W-1:0]   x_lo;
    s     = loba_split_reset();
    sh_hi = p - LOBA_K_MIN_V;
    sh_lo = p - LOBA_LO_OFS;
    x_hi  = x >> sh_hi;
    rem   = x & ~({{(LOBA_W-LOBA_SEG){1'b0}}, {LOBA_SEG{1'b1}}} << sh_hi);
    x_lo  = rem >> sh_lo;
    if (!nz) begin
      s = loba_split_reset();
    end else if (p < LOBA_K_MIN_V) begin
      // Whole operand fits in the bottom segment.
      s.xh = x[LOBA_SEG-1:0];
    end else if (p <= LOBA_P_EXACT) begin
      // Remainder lies entirely in bits [3:0]: exact split.
      s.xh = x_hi[LOBA_SEG-1:0];
      s.kh = p;
      s.xl = rem[LOBA_SEG-1:0];
    end else begin
      // Low segment directly under the high one; lower bits are dropped.
      s.xh = x_hi[LOBA_SEG-1:0];
      s.kh = p;
      s.xl = x_lo[LOBA_SEG-1:0];
      s.kl = p - LOBA_SEG_STEP;
    end
`ifdef LOBA_SPLIT_ZERO_FLAG_EN
    s.zero = ~nz;
`endif
    return s;
  endfunction

endpackage

// File: rtl/loba_split_pipe_lod.sv
// loba_lod: combinational leading-one detector.
//
// Ports:
//   i_x        in  W   operand
//   o_p        out KW  index of the most significant set bit (0 when i_x is 0)
//   o_nonzero  out 1   i_x has at least one set bit
module loba_lod
  import loba_pkg::*;
#(
  parameter int W  = LOBA_W,
  parameter int KW = LOBA_KW
) (
  input  logic [W-1:0]  i_x,
  output logic [KW-1:0] o_p,
  output logic          o_nonzero
);

  // Priority scan: later (higher) set bits override earlier ones.
  always_comb begin
    o_p = {KW{1'b0}};
    for (int i = 0; i < W; i++) begin
      o_p = i_x[i] ? KW'(i) : o_p;
    end
    o_nonzero = |i_x;
  end

endmodule

// File: rtl/loba_split_pipe.sv
// loba_split_pipe: two-stage operand-splitting front end for the LOBA2
// approximate multiplier. Stage 1 registers the operands with their
// leading-one index; stage 2 extracts high/low segments and shift positions
// and holds them on the outputs.
//
// Optional feature macro: LOBA_SPLIT_ZERO_FLAG_EN adds a_zero_o / b_zero_o.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        operand-pair handshake (in_ready is combinational
//                              on out_ready; no skid buffer)
//   a_i, b_i                   unsigned operands
//   out_valid / out_ready      result handshake
//   ah_o, al_o, bh_o, bl_o     high/low segments
//   k1a_o, k2a_o, k1b_o, k2b_o segment MSB positions (always >= 3)
//   a_zero_o, b_zero_o         operand was zero (macro only)
module loba_split_pipe
  import loba_pkg::*;
#(
  parameter int W   = LOBA_W,
  parameter int SEG = LOBA_SEG,
  parameter int KW  = LOBA_KW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SEG-1:0] ah_o,
  output logic [SEG-1:0] al_o,
  output logic [SEG-1:0] bh_o,
  output logic [SEG-1:0] bl_o,
  output logic [KW-1:0]  k1a_o,
  output logic [KW-1:0]  k2a_o,
  output logic [KW-1:0]  k1b_o,
  output logic [KW-1:0]  k2b_o
`ifdef LOBA_SPLIT_ZERO_FLAG_EN
  ,
  output logic           a_zero_o,
  output logic           b_zero_o
`endif
);

  logic [KW-1:0] w_pa;
  logic [KW-1:0] w_pb;
  logic          w_nza;
  logic          w_nzb;
  logic          w_s1_load;
  logic          w_s2_load;
  logic          w_in_ready;

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_a;
  logic [W-1:0]  r_s1_b;
  logic [KW-1:0] r_s1_pa;
  logic [KW-1:0] r_s1_pb;
  logic          r_s1_nza;
  logic          r_s1_nzb;

  logic          r_s2_valid;
  loba_split_t   r_s2_a;
  loba_split_t   r_s2_b;

  loba_lod #(.W(W), .KW(KW)) u_lod_a (
    .i_x       (a_i),
    .o_p       (w_pa),
    .o_nonzero (w_nza)
  );

  loba_lod #(.W(W), .KW(KW)) u_lod_b (
    .i_x       (b_i),
    .o_p       (w_pb),
    .o_nonzero (w_nzb)
  );

  // Handshake: s2 frees space when it is empty or draining, which lets s1
  // accept a new pair in the same cycle it hands off (no bubble).
  always_comb begin
    w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    w_in_ready = !r_s1_valid || w_s2_load;
    w_s1_load  = in_valid && w_in_ready;
  end

  // Stage 1: capture operands, leading-one index and nonzero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= {W{1'b0}};
      r_s1_b     <= {W{1'b0}};
      r_s1_pa    <= {KW{1'b0}};
      r_s1_pb    <= {KW{1'b0}};
      r_s1_nza   <= 1'b0;
      r_s1_nzb   <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
      if (w_s1_load) begin
        r_s1_a   <= a_i;
        r_s1_b   <= b_i;
        r_s1_pa  <= w_pa;
        r_s1_pb  <= w_pb;
        r_s1_nza <= w_nza;
        r_s1_nzb <= w_nzb;
      end else begin
        r_s1_a   <= r_s1_a;
        r_s1_b   <= r_s1_b;
        r_s1_pa  <= r_s1_pa;
        r_s1_pb  <= r_s1_pb;
        r_s1_nza <= r_s1_nza;
        r_s1_nzb <= r_s1_nzb;
      end
    end
  end

  // Stage 2: split both operands into the output registers; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_a     <= loba_split_reset();
      r_s2_b     <= loba_split_reset();
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_a     <= loba_split(r_s1_a, r_s1_pa, r_s1_nza);
        r_s2_b     <= loba_split(r_s1_b, r_s1_pb, r_s1_nzb);
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
        r_s2_a     <= r_s2_a;
        r_s2_b     <= r_s2_b;
      end else begin
        r_s2_valid <= r_s2_valid;
        r_s2_a     <= r_s2_a;
        r_s2_b     <= r_s2_b;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign ah_o      = r_s2_a.xh;
  assign k1a_o     = r_s2_a.kh;
  assign al_o      = r_s2_a.xl;
  assign k2a_o     = r_s2_a.kl;
  assign bh_o      = r_s2_b.xh;
  assign k1b_o     = r_s2_b.kh;
  assign bl_o      = r_s2_b.xl;
  assign k2b_o     = r_s2_b.kl;
`ifdef LOBA_SPLIT_ZERO_FLAG_EN
  assign a_zero_o  = r_s2_a.zero;
  assign b_zero_o  = r_s2_b.zero;
`endif

endmodule
